// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Round-robin issue arbiter in front of the single shared 16-bit ALU.
// Two requesters: req0 = execute stage, req1 = address/branch unit.
// Accepts one op, drives the ALU with the latched operands (held steady
// through a multi-cycle multiply), registers the result, and returns it on
// the owner's valid/ready response channel.
// Optional build macro: ALU_FLAGS_EN adds the registered resp_zero output.
module alu_issue_arbiter #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter logic [3:0]  IDLE_CTRL  = 4'b1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic [3:0]  alu_ctrl,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_dout
`ifdef ALU_FLAGS_EN
    ,
    output logic        resp_zero
`endif
);

    localparam logic [3:0] OP_MUL   = 4'b0011;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        owner_q;
    logic        lastGrant_q;
    logic [3:0]  aluCtrl_q;
    logic [15:0] aluA_q;
    logic [15:0] aluB_q;
    logic [15:0] respData_q;
    logic        respErr_q;
    logic        resp0Valid_q;
    logic        resp1Valid_q;
`ifdef ALU_FLAGS_EN
    logic        respZero_q;
`endif

    logic        grantValid_d;
    logic        grant1_d;
    logic [3:0]  op_d;
    logic [15:0] a_d;
    logic [15:0] b_d;
    logic        illegal_d;

    // Choose this cycle's winner: a lone requester wins, a tie goes to whoever was not granted last.
    always_comb begin
        grantValid_d = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
        grant1_d     = req1_valid && (!req0_valid || !lastGrant_q);
        op_d         = grant1_d ? req1_op : req0_op;
        a_d          = grant1_d ? req1_a  : req0_a;
        b_d          = grant1_d ? req1_b  : req0_b;
        illegal_d    = (op_d == 4'b0000) || (op_d == 4'b1100) ||
                       (op_d == 4'b1101) || (op_d == 4'b1111);
    end

    assign req0_ready = grantValid_d && !grant1_d;
    assign req1_ready = grantValid_d && grant1_d;

    // Sequencer: accept in IDLE, hold the ALU inputs through EXEC, present the result in RESP until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            lastGrant_q  <= 1'b1;
            aluCtrl_q    <= IDLE_CTRL;
            aluA_q       <= 16'h0000;
            aluB_q       <= 16'h0000;
            respData_q   <= 16'h0000;
            respErr_q    <= 1'b0;
            resp0Valid_q <= 1'b0;
            resp1Valid_q <= 1'b0;
`ifdef ALU_FLAGS_EN
            respZero_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grantValid_d) begin
                        owner_q     <= grant1_d;
                        lastGrant_q <= grant1_d;
                        if (illegal_d) begin
                            state_q      <= RESP;
                            respData_q   <= 16'h0000;
                            respErr_q    <= 1'b1;
                            resp0Valid_q <= !grant1_d;
                            resp1Valid_q <= grant1_d;
`ifdef ALU_FLAGS_EN
                            respZero_q   <= 1'b0;
`endif
                        end else begin
                            state_q   <= EXEC;
                            cnt_q     <= (op_d == OP_MUL) ? MUL_LOAD : 4'd0;
                            aluCtrl_q <= op_d;
                            aluA_q    <= a_d;
                            aluB_q    <= b_d;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q      <= RESP;
                        respData_q   <= alu_dout;
                        respErr_q    <= 1'b0;
                        resp0Valid_q <= !owner_q;
                        resp1Valid_q <= owner_q;
`ifdef ALU_FLAGS_EN
                        respZero_q   <= (alu_dout == 16'h0000);
`endif
                        aluCtrl_q    <= IDLE_CTRL;
                        aluA_q       <= 16'h0000;
                        aluB_q       <= 16'h0000;
                    end
                end
                RESP: begin
                    if (owner_q ? resp1_ready : resp0_ready) begin
                        state_q      <= IDLE;
                        resp0Valid_q <= 1'b0;
                        resp1Valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp0_valid = resp0Valid_q;
    assign resp1_valid = resp1Valid_q;
    assign resp_data   = respData_q;
    assign resp_err    = respErr_q;
    assign alu_ctrl    = aluCtrl_q;
    assign alu_a       = aluA_q;
    assign alu_b       = aluB_q;
`ifdef ALU_FLAGS_EN
    assign resp_zero   = respZero_q;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter
// Bench for alu_issue_arbiter: directed vector table, hand-written corner
// sequences (contention, back-pressure, mid-op reset) and a randomized
// phase checked against a transaction-level reference model.
// Honours ALU_FLAGS_EN when defined (checks resp_zero).
module tb_alu_issue_arbiter;

    localparam int MUL = 3;

    typedef struct {
        logic        who;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expData;
        logic        expErr;
        int          expLat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op, alu_ctrl;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready, resp_err;
    logic [15:0] resp_data, alu_a, alu_b, alu_dout;
`ifdef ALU_FLAGS_EN
    logic        resp_zero;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    vec_t vecs[10];

    alu_issue_arbiter #(.MUL_CYCLES(MUL), .IDLE_CTRL(4'b1000)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_dout(alu_dout)
`ifdef ALU_FLAGS_EN
        , .resp_zero(resp_zero)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the shared ALU instance.
    function automatic logic [15:0] aluModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] prod;
        prod = 32'(a) * 32'(b);
        case (op)
            4'b0001: return a + b;
            4'b0010: return a - b;
            4'b0011: return prod[15:0];
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return a ^ b;
            4'b0111: return a << b[3:0];
            4'b1000: return a;
            4'b1001: return a >> b[3:0];
            4'b1010: return ~a;
            4'b1011: return a + 16'd1;
            4'b1110: return b;
            default: return 16'hDEAD;
        endcase
    endfunction

    assign alu_dout = aluModel(alu_ctrl, alu_a, alu_b);

    function automatic logic isIllegal(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b1100) || (op == 4'b1101) || (op == 4'b1111);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                                 input logic v1, input logic [3:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                                 input logic r0, input logic r1);
        req0_valid  = v0;
        req0_op     = op0;
        req0_a      = a0;
        req0_b      = b0;
        req1_valid  = v1;
        req1_op     = op1;
        req1_a      = a1;
        req1_b      = b1;
        resp0_ready = r0;
        resp1_ready = r1;
    endtask

    task automatic checkAluIdle(input string name);
        checkOutput({name, "_aluCtrl"}, alu_ctrl, 4'b1000);
        checkOutput({name, "_aluA"}, alu_a, 16'h0000);
        checkOutput({name, "_aluB"}, alu_b, 16'h0000);
    endtask

    // One directed transaction: starts and ends just after a rising edge.
    task automatic runTxn(input vec_t v, input string tag);
        int lat;
        if (!v.who) applyStimulus(1'b1, v.op, v.a, v.b, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        else        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, v.op, v.a, v.b, 1'b0, 1'b0);
        settle();
        checkOutput({tag, "_ready"}, v.who ? req1_ready : req0_ready, 1'b1);
        checkOutput({tag, "_otherReady"}, v.who ? req0_ready : req1_ready, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        settle();
        lat = 1;
        while (!(resp0_valid || resp1_valid) && lat < 20) begin
            checkOutput({tag, "_execCtrl"}, alu_ctrl, v.op);
            checkOutput({tag, "_execA"}, alu_a, v.a);
            checkOutput({tag, "_execB"}, alu_b, v.b);
            tick();
            settle();
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, v.expLat);
        checkOutput({tag, "_ownValid"}, v.who ? resp1_valid : resp0_valid, 1'b1);
        checkOutput({tag, "_otherValid"}, v.who ? resp0_valid : resp1_valid, 1'b0);
        checkOutput({tag, "_data"}, resp_data, v.expData);
        checkOutput({tag, "_err"}, resp_err, v.expErr);
`ifdef ALU_FLAGS_EN
        checkOutput({tag, "_zero"}, resp_zero, !v.expErr && (v.expData == 16'h0000));
`endif
        checkAluIdle({tag, "_resp"});
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, !v.who, v.who);
        tick();
        settle();
        checkOutput({tag, "_validDropped"}, resp0_valid | resp1_valid, 1'b0);
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin : mainTest
        int          grantSeq[$];
        logic [31:0] dataSeq[$];

        vecs[0] = '{1'b0, 4'b0001, 16'd3,     16'd4,     16'h0007, 1'b0, 2};
        vecs[1] = '{1'b1, 4'b0011, 16'h0101,  16'h0100,  16'h0100, 1'b0, 1 + MUL};
        vecs[2] = '{1'b0, 4'b1111, 16'h1234,  16'h5678,  16'h0000, 1'b1, 1};
        vecs[3] = '{1'b1, 4'b0000, 16'h0042,  16'h0001,  16'h0000, 1'b1, 1};
        vecs[4] = '{1'b0, 4'b0010, 16'd9,     16'd2,     16'h0007, 1'b0, 2};
        vecs[5] = '{1'b1, 4'b0010, 16'd5,     16'd5,     16'h0000, 1'b0, 2};
        vecs[6] = '{1'b0, 4'b1100, 16'hFFFF,  16'hFFFF,  16'h0000, 1'b1, 1};
        vecs[7] = '{1'b1, 4'b0011, 16'h0003,  16'h0005,  16'h000F, 1'b0, 1 + MUL};
        vecs[8] = '{1'b0, 4'b1000, 16'hABCD,  16'h0001,  16'hABCD, 1'b0, 2};
        vecs[9] = '{1'b1, 4'b1101, 16'h0007,  16'h0007,  16'h0000, 1'b1, 1};

        // Reset values
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        settle();
        checkOutput("rst_resp0Valid", resp0_valid, 1'b0);
        checkOutput("rst_resp1Valid", resp1_valid, 1'b0);
        checkOutput("rst_ready", req0_ready | req1_ready, 1'b0);
        checkOutput("rst_data", resp_data, 16'h0000);
        checkOutput("rst_err", resp_err, 1'b0);
        checkAluIdle("rst");
`ifdef ALU_FLAGS_EN
        checkOutput("rst_zero", resp_zero, 1'b0);
`endif
        rst = 1'b0;
        tick();

        // Continuous contention straight out of reset: req0 first, then strict alternation.
        applyStimulus(1'b1, 4'b0001, 16'd1, 16'd1, 1'b1, 4'b0001, 16'd5, 16'd5, 1'b1, 1'b1);
        for (int c = 0; c < 14; c++) begin
            settle();
            if (req0_ready) grantSeq.push_back(0);
            if (req1_ready) grantSeq.push_back(1);
            if (resp0_valid || resp1_valid) dataSeq.push_back({15'd0, resp1_valid, resp_data});
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput("cont_grant", (i < grantSeq.size()) ? grantSeq[i] : 99, i % 2);
            checkOutput("cont_resp", (i < dataSeq.size()) ? dataSeq[i] : 32'hFFFF_FFFF,
                        (i % 2 == 1) ? 32'h0001_000A : 32'h0000_0002);
        end
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) tick();
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            runTxn(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: result held while resp0_ready stays low, req1 locked out meanwhile.
        applyStimulus(1'b1, 4'b0001, 16'h00F0, 16'h000F, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        settle();
        checkOutput("bp_accept", req0_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 4'b0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
        settle();
        checkOutput("bp_execReady1", req1_ready, 1'b0);
        tick();
        settle();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", resp0_valid, 1'b1);
            checkOutput("bp_data", resp_data, 16'h00FF);
            checkOutput("bp_err", resp_err, 1'b0);
            checkOutput("bp_ready1", req1_ready, 1'b0);
            tick();
            settle();
        end
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 4'b0001, 16'h0001, 16'h0002, 1'b1, 1'b0);
        settle();
        checkOutput("bp_releaseValid", resp0_valid, 1'b1);
        checkOutput("bp_releaseReady1", req1_ready, 1'b0);
        tick();
        settle();
        checkOutput("bp_afterValid", resp0_valid, 1'b0);
        checkOutput("bp_afterReady1", req1_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1);
        settle();
        for (int i = 0; i < 10 && !resp1_valid; i++) begin
            tick();
            settle();
        end
        checkOutput("bp_req1Valid", resp1_valid, 1'b1);
        checkOutput("bp_req1Data", resp_data, 16'h0003);
        tick();
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();

        // Reset in the middle of a multiply abandons it without a response.
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 4'b0011, 16'h0007, 16'h0007, 1'b1, 1'b1);
        settle();
        checkOutput("mrst_accept", req1_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        tick();
        settle();
        checkOutput("mrst_execCtrl", alu_ctrl, 4'b0011);
        rst = 1'b1;
        #1;
        checkOutput("mrst_resp1Valid", resp1_valid, 1'b0);
        checkOutput("mrst_resp0Valid", resp0_valid, 1'b0);
        checkOutput("mrst_data", resp_data, 16'h0000);
        checkOutput("mrst_err", resp_err, 1'b0);
        checkAluIdle("mrst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            checkOutput("mrst_noResp", resp0_valid | resp1_valid, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        runTxn(vecs[4], "mrst_next");

        // Randomized traffic against a transaction-level model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        begin : randomPhase
            logic        p0v, p1v, r0, r1, lastG, g1, gv, own, expErr;
            logic [3:0]  p0op, p1op, xop;
            logic [15:0] p0a, p0b, p1a, p1b, xa, xb, expData;
            bit          busy;
            int          age, expLat;
            p0v = 1'b0; p1v = 1'b0; lastG = 1'b1; busy = 1'b0; age = 0; expLat = 0;
            own = 1'b0; expErr = 1'b0; expData = 16'h0; xop = 4'h0; xa = 16'h0; xb = 16'h0;
            p0op = 4'h0; p1op = 4'h0; p0a = 16'h0; p0b = 16'h0; p1a = 16'h0; p1b = 16'h0;
            for (int c = 0; c < 400; c++) begin
                if (!p0v && $urandom_range(0, 99) < 40) begin
                    p0v = 1'b1; p0op = 4'($urandom);
                    p0a = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                    p0b = ($urandom_range(0, 3) == 0) ? p0a : 16'($urandom);
                end
                if (!p1v && $urandom_range(0, 99) < 40) begin
                    p1v = 1'b1; p1op = 4'($urandom);
                    p1a = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                    p1b = ($urandom_range(0, 3) == 0) ? p1a : 16'($urandom);
                end
                r0 = ($urandom_range(0, 99) < 60);
                r1 = ($urandom_range(0, 99) < 60);
                applyStimulus(p0v, p0op, p0a, p0b, p1v, p1op, p1a, p1b, r0, r1);
                settle();
                if (!busy) begin
                    gv = p0v || p1v;
                    g1 = p1v && (!p0v || !lastG);
                    checkOutput("rnd_ready0", req0_ready, gv && !g1);
                    checkOutput("rnd_ready1", req1_ready, g1);
                    checkOutput("rnd_idleValid", resp0_valid | resp1_valid, 1'b0);
                    checkAluIdle("rnd_idle");
                    if (gv) begin
                        busy    = 1'b1;
                        own     = g1;
                        lastG   = g1;
                        age     = 0;
                        xop     = g1 ? p1op : p0op;
                        xa      = g1 ? p1a : p0a;
                        xb      = g1 ? p1b : p0b;
                        expErr  = isIllegal(xop);
                        expData = expErr ? 16'h0000 : aluModel(xop, xa, xb);
                        expLat  = expErr ? 1 : ((xop == 4'b0011) ? 1 + MUL : 2);
                        if (g1) p1v = 1'b0;
                        else    p0v = 1'b0;
                    end
                end else begin
                    checkOutput("rnd_busyReady", req0_ready | req1_ready, 1'b0);
                    if (age < expLat) begin
                        checkOutput("rnd_execValid", resp0_valid | resp1_valid, 1'b0);
                        checkOutput("rnd_execAlu", {alu_ctrl, alu_a, alu_b}, {xop, xa, xb});
                    end else begin
                        checkOutput("rnd_ownValid", own ? resp1_valid : resp0_valid, 1'b1);
                        checkOutput("rnd_otherValid", own ? resp0_valid : resp1_valid, 1'b0);
                        checkOutput("rnd_data", resp_data, expData);
                        checkOutput("rnd_err", resp_err, expErr);
`ifdef ALU_FLAGS_EN
                        checkOutput("rnd_zero", resp_zero, !expErr && (expData == 16'h0000));
`endif
                        checkAluIdle("rnd_resp");
                        if (own ? r1 : r0) busy = 1'b0;
                    end
                end
                if (busy) age++;
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Sequences and shares the single combinational 16-bit ALU between two requesters: req0 is the execute stage and req1 is the address/branch unit.
- Arbitrates requests round-robin, latches the operands and drives the ALU inputs.
- Holds the ALU inputs stable for multi-cycle multiply, registers the result and returns it with a valid/ready response handshake.
- Sits between the issue logic and the ALU instance; it is the only driver of the ALU inputs.

Parameters:
- MUL_CYCLES, 3, number of EXEC cycles held for opcode 4'b0011 (mul); legal range 1..15.
- IDLE_CTRL, 4'b1000, ALU control driven when not in EXEC (mv).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_op / req1_op  input  4  ALU opcode.
- req0_a / req1_a  input  16  operand 1.
- req0_b / req1_b  input  16  operand 2.
- resp0_valid / resp1_valid  output  1  result available for that requester.
- resp0_ready / resp1_ready  input  1  requester consumes result.
- resp_data  output  16  registered result, shared by both response channels.
- resp_err  output  1  illegal opcode flag, qualified by respN_valid.
- alu_ctrl  output  4  to ALU Aluctrl.
- alu_a  output  16  to ALU din1.
- alu_b  output  16  to ALU din2.
- alu_dout  input  16  from ALU dout.

Behaviour:
- **Reset:** asynchronous on rst=1; applies mid-operation too, abandoning any in-flight op with no response.
  - state=IDLE, cnt=0, owner=0, last_grant=1 (so req0 wins first).
  - resp_data=0, resp_err=0, all ready/valid outputs 0.
  - alu_ctrl=IDLE_CTRL, alu_a=0, alu_b=0.
- **States:** IDLE, EXEC, RESP.
- **IDLE:**
  - Grant rule: one requester valid → grant it. Both valid → grant the requester that is not last_grant.
  - reqN_ready is combinational, asserted only in IDLE and only for the granted N.
  - On the granting edge: latch op/a/b, set owner=N, set last_grant=N.
  - Illegal opcode (0000, 1100, 1101, 1111) → go to RESP with resp_data=0, resp_err=1; no ALU cycle.
  - mul → go to EXEC with cnt=MUL_CYCLES-1.
  - All other legal opcodes → go to EXEC with cnt=0.
- **EXEC:**
  - alu_ctrl/alu_a/alu_b = latched op/a/b, held constant for the whole state.
  - cnt!=0 → decrement cnt.
  - cnt==0 → capture resp_data=alu_dout, resp_err=0, go to RESP.
- **RESP:**
  - resp<owner>_valid=1; the other response valid stays 0.
  - resp_data/resp_err are held stable until the handshake completes.
  - resp<owner>_ready=1 → go to IDLE. The next grant earliest occurs in the following cycle; no same-cycle re-grant.
  - respN_ready for the non-owner is ignored.
- **ALU inputs outside EXEC:** IDLE_CTRL, 0, 0.
- **Latency** (accept edge = cycle 0): single-cycle op → respN_valid high in cycle 2; mul → cycle 1+MUL_CYCLES; illegal → cycle 1.
- **Throughput:** at most one op per 3 cycles; no pipelining or overlap.
- **Width:** resp_data is the low 16 bits of whatever the ALU returns; this block does no arithmetic.
- **Request inputs:** a requester must hold valid/op/a/b stable until its ready is seen. Inputs while not granted are ignored.
- **Starvation:** none; under continuous contention grants strictly alternate 0,1,0,1.

Optional Feature:
- **Macro:** ALU_FLAGS_EN.
- **Defined:** adds output resp_zero (1 bit), registered with resp_data, =1 when the captured result ==16'h0000. Forced 0 when resp_err=1; reset value 0.
- **Undefined:** port absent, no extra logic; all other behaviour identical.

Test Plan:
- req0 op=0001 a=3 b=4, resp0_ready=1 → req0_ready in cycle 0, resp0_valid in cycle 2, resp_data=16'h0007, resp_err=0.
- req1 op=0011 a=16'h0101 b=16'h0100, MUL_CYCLES=3 → alu_ctrl=0011 held 3 cycles, resp1_valid in cycle 4, resp_data=16'h0100.
- req0 and req1 both valid continuously with op=0001 → first grant req0 (a=1,b=1 → 2), then req1 (a=5,b=5 → 10), then req0; grants alternate and resp_data values match.
- resp0_ready held 0 for 5 cycles after result 16'h00FF → resp0_valid and resp_data stay stable, req1_ready stays 0; release → IDLE next cycle.
- req0 op=1111 → resp0_valid in cycle 1, resp_err=1, resp_data=0; ALU inputs never leave IDLE_CTRL/0/0.
- rst pulsed during EXEC of a mul → all outputs at reset values immediately; no response issued; next request req0 op=0010 a=9 b=2 → 16'h0007. With ALU_FLAGS_EN defined, op=0010 a=5 b=5 → resp_zero=1.
